// File: rtl/slot_pkg.sv
// Shared types and helpers for the N-reel slot controller.
// Holds the FSM state encoding, 7-segment decode and LED bit positions.
package slot_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    JUDGE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int LED_STATE_LO = 4;
  localparam int LED_BZ       = 6;
  localparam int LED_NWIN     = 7;

  // Active-low gfedcba pattern; 10..15 render as hex letters A..F.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      4'hF:    return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/psw_debounce.sv
// Push-switch conditioner: 2-FF synchroniser, stable-sample debounce and
// a one-cycle PRESS pulse on each debounced release-to-press transition.
module psw_debounce #(
  parameter int DB_LEN = 3
) (
  input  logic CK,
  input  logic RST,
  input  logic PSW_N,
  output logic PRESS
);

  localparam int CW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Level only follows the synced input after DB_LEN consecutive differing samples.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      PRESS   <= 1'b0;
    end else begin
      sync1   <= PSW_N;
      sync2   <= sync1;
      level_d <= level;
      PRESS   <= level_d & ~level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/slot_reel_ctrl.sv
// N-reel slot controller: spinning reels stopped left to right by one switch,
// all-equal judge with buzzer pulse, registered 7-seg and status LED outputs.
module slot_reel_ctrl
  import slot_pkg::*;
#(
  parameter int NREEL    = 3,
  parameter int DIGITS   = 10,
  parameter int TICK_DIV = 4,
  parameter int DB_LEN   = 3,
  parameter int BZ_LEN   = 16
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               PSW,
  output logic [NREEL*8-1:0] SEG,
  output logic               BZ,
  output logic [7:0]         LED
);

  localparam int VW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BZ_LEN + 1);
  localparam logic [VW-1:0] VAL_MAX = VW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BZ_LOAD = BW'(BZ_LEN - 1);

  logic                press;
  logic [PW-1:0]       presc;
  logic                tick;
  state_t              state;
  state_t              next_state;
  logic [NREEL-1:0]    stopped;
  logic [NREEL-1:0]    stop_bit;
  logic [NREEL-1:0]    stop_set;
  logic                restart;
  logic                win;
  logic                win_now;
  logic [BW-1:0]       bz_cnt;
  logic [NREEL*VW-1:0] reel_flat;
  logic [7:0]          led_next;

  psw_debounce #(.DB_LEN(DB_LEN)) u_db (
    .CK    (CK),
    .RST   (RST),
    .PSW_N (PSW),
    .PRESS (press)
  );

  assign tick     = (presc == PRE_MAX);
  // Lowest clear bit of stopped: the next reel to stop.
  assign stop_bit = ~stopped & (stopped + NREEL'(1));

  for (genvar i = 0; i < NREEL; i++) begin : g_reel
    logic [VW-1:0] value;
    logic [1:0]    div;

    // Reel i steps once every (i+1) ticks; frozen while stopped or being stopped.
    always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
        value <= '0;
        div   <= 2'd0;
      end else if (restart) begin
        div <= 2'd0;
      end else if (tick && !stopped[i] && !stop_set[i]) begin
        if (div == 2'(i)) begin
          div   <= 2'd0;
          value <= (value == VAL_MAX) ? '0 : value + VW'(1);
        end else begin
          div <= div + 2'd1;
        end
      end
    end

    assign reel_flat[i*VW +: VW] = value;
  end

  // All-equal comparison against the leftmost reel.
  always_comb begin
    win_now = 1'b1;
    for (int i = 1; i < NREEL; i++) begin
      win_now = win_now & (reel_flat[i*VW +: VW] == reel_flat[VW-1:0]);
    end
  end

  // Next-state logic; presses arriving in JUDGE fall through unused.
  always_comb begin
    next_state = state;
    stop_set   = '0;
    restart    = 1'b0;
    case (state)
      RUN: begin
        if (press) begin
          stop_set   = stop_bit;
          next_state = stop_bit[NREEL-1] ? JUDGE : RUN;
        end else begin
          next_state = RUN;
        end
      end
      JUDGE: next_state = HOLD;
      HOLD: begin
        if (press) begin
          restart    = 1'b1;
          next_state = RUN;
        end else begin
          next_state = HOLD;
        end
      end
      default: next_state = RUN;
    endcase
  end

  // State, prescaler, stop flags, win flag and buzzer timer.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state   <= RUN;
      presc   <= '0;
      stopped <= '0;
      win     <= 1'b0;
      BZ      <= 1'b0;
      bz_cnt  <= '0;
    end else begin
      state   <= next_state;
      presc   <= tick ? '0 : presc + PW'(1);
      stopped <= restart ? '0 : (stopped | stop_set);
      if (state == JUDGE) begin
        win    <= win_now;
        BZ     <= win_now;
        bz_cnt <= BZ_LOAD;
      end else if (restart) begin
        win <= 1'b0;
        BZ  <= 1'b0;
      end else if (BZ) begin
        if (bz_cnt == '0) begin
          BZ <= 1'b0;
        end else begin
          bz_cnt <= bz_cnt - BW'(1);
        end
      end
    end
  end

  always_comb begin
    led_next                      = 8'h00;
    led_next[NREEL-1:0]           = stopped;
    led_next[LED_STATE_LO +: 2]   = state;
    led_next[LED_BZ]              = BZ;
    led_next[LED_NWIN]            = ~win;
  end

  // Display and status registers, one cycle behind the internal state.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      SEG <= {NREEL{8'hC0}};
      LED <= 8'h80;
    end else begin
      for (int i = 0; i < NREEL; i++) begin
        SEG[i*8 +: 8] <= {~stopped[i], seg7(4'(reel_flat[i*VW +: VW]))};
      end
      LED <= led_next;
    end
  end

endmodule
